// File: rtl/axi_stream_extract_header.sv
// AXI-Stream header extractor: splits the first N bytes of each packet onto a header
// channel and re-packs the rest left-aligned. Optional short_pkt flag: AXIS_EXTRACT_SHORT_DET_EN.
module axi_stream_extract_header #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic [2:0]              strip_len,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  output logic                    valid_header,
  output logic [DATA_WD-1:0]      header_out,
  output logic [DATA_BYTE_WD-1:0] keep_header,
  input  logic                    ready_header
`ifdef AXIS_EXTRACT_SHORT_DET_EN
  ,
  output logic                    short_pkt
`endif
);

  typedef enum logic [1:0] {S_SOP, S_BODY, S_FLUSH} state_e;

  function automatic logic [2:0] popcount(input logic [DATA_BYTE_WD-1:0] k);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) cnt = cnt + 3'(k[i]);
    return cnt;
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [2:0] r);
    return ~({DATA_BYTE_WD{1'b1}} >> r);
  endfunction

  function automatic logic [DATA_BYTE_WD-1:0] low_mask(input logic [2:0] r);
    return ~({DATA_BYTE_WD{1'b1}} << r);
  endfunction

  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  state_e                  state_q, state_d;
  logic [2:0]              n_q, n_d;
  logic [DATA_WD-1:0]      res_q, res_d;
  logic [DATA_BYTE_WD-1:0] fkeep_q, fkeep_d;

  logic                    out_load, out_last;
  logic [DATA_WD-1:0]      out_data;
  logic [DATA_BYTE_WD-1:0] out_keep;
  logic                    hdr_load;
  logic [DATA_WD-1:0]      hdr_data;
  logic [DATA_BYTE_WD-1:0] hdr_keep;

  logic [2:0]              n_in, k_in;
  logic                    out_free, hdr_free;
  logic [DATA_WD-1:0]      merged;

  assign n_in     = (strip_len > 3'd4) ? 3'd4 : strip_len;
  assign k_in     = popcount(keep_in);
  assign out_free = !valid_out || ready_out;
  assign hdr_free = !valid_header || ready_header;
  // Residual bytes sit left-aligned; the new beat's top N bytes fill the low end.
  assign merged   = res_q | (data_in >> {3'd4 - n_q, 3'b000});

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    n_d      = n_q;
    res_d    = res_q;
    fkeep_d  = fkeep_q;
    ready_in = 1'b0;
    out_load = 1'b0;
    out_data = '0;
    out_keep = '0;
    out_last = 1'b0;
    hdr_load = 1'b0;
    hdr_data = '0;
    hdr_keep = '0;

    unique case (state_q)
      S_SOP: begin
        ready_in = hdr_free && out_free;
        if (valid_in && hdr_free && out_free) begin
          n_d = n_in;
          if (n_in == 3'd0) begin
            out_load = 1'b1;
            out_data = data_in;
            out_keep = keep_in;
            out_last = last_in;
            state_d  = last_in ? S_SOP : S_BODY;
          end else begin
            hdr_load = 1'b1;
            hdr_data = data_in >> {3'd4 - n_in, 3'b000};
            hdr_keep = low_mask((k_in < n_in) ? k_in : n_in);
            if (last_in) begin
              // A single-beat packet only produces payload if it outlives the header.
              if (k_in > n_in) begin
                out_load = 1'b1;
                out_keep = keep_in << n_in;
                out_data = (data_in << {n_in, 3'b000}) & byte_mask(keep_in << n_in);
                out_last = 1'b1;
              end
              state_d = S_SOP;
            end else begin
              res_d   = data_in << {n_in, 3'b000};
              state_d = S_BODY;
            end
          end
        end
      end

      S_BODY: begin
        ready_in = out_free;
        if (valid_in && out_free) begin
          out_load = 1'b1;
          if (n_q == 3'd0) begin
            out_data = data_in;
            out_keep = keep_in;
            out_last = last_in;
            state_d  = last_in ? S_SOP : S_BODY;
          end else if (!last_in) begin
            out_data = merged;
            out_keep = '1;
            res_d    = data_in << {n_q, 3'b000};
          end else if (k_in <= n_q) begin
            out_keep = top_mask(3'd4 - n_q + k_in);
            out_data = merged & byte_mask(top_mask(3'd4 - n_q + k_in));
            out_last = 1'b1;
            state_d  = S_SOP;
          end else begin
            out_data = merged;
            out_keep = '1;
            res_d    = data_in << {n_q, 3'b000};
            fkeep_d  = keep_in << n_q;
            state_d  = S_FLUSH;
          end
        end
      end

      S_FLUSH: begin
        if (out_free) begin
          out_load = 1'b1;
          out_data = res_q & byte_mask(fkeep_q);
          out_keep = fkeep_q;
          out_last = 1'b1;
          state_d  = S_SOP;
        end
      end

      default: state_d = S_SOP;
    endcase

    if (!rst_n) ready_in = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_SOP;
      n_q          <= '0;
      res_q        <= '0;
      fkeep_q      <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      keep_out     <= '0;
      last_out     <= 1'b0;
      valid_header <= 1'b0;
      header_out   <= '0;
      keep_header  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      res_q   <= res_d;
      fkeep_q <= fkeep_d;

      if (out_load) begin
        valid_out <= 1'b1;
        data_out  <= out_data;
        keep_out  <= out_keep;
        last_out  <= out_last;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end

      if (hdr_load) begin
        valid_header <= 1'b1;
        header_out   <= hdr_data;
        keep_header  <= hdr_keep;
      end else if (ready_header) begin
        valid_header <= 1'b0;
      end
    end
  end

`ifdef AXIS_EXTRACT_SHORT_DET_EN
  // Running byte count per packet, saturating; only needs to resolve totals up to 4.
  logic [2:0] byte_cnt_q;
  logic [3:0] byte_sum;
  logic [2:0] pkt_n;

  always_comb begin
    byte_sum = (state_q == S_SOP) ? {1'b0, k_in} : ({1'b0, byte_cnt_q} + {1'b0, k_in});
    pkt_n    = (state_q == S_SOP) ? n_in : n_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      short_pkt  <= 1'b0;
    end else begin
      short_pkt <= 1'b0;
      if (valid_in && ready_in) begin
        byte_cnt_q <= (byte_sum > 4'd7) ? 3'd7 : byte_sum[2:0];
        short_pkt  <= last_in && (byte_sum <= {1'b0, pkt_n});
      end
    end
  end
`endif

endmodule
